// File: rtl/regfile_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : regfile_rd_ctrl
// Purpose  : Read-side controller for the general register file. Accepts a
//            (start address, word count) command, issues one synchronous read
//            at a time, captures the returned word and streams it out on a
//            valid/ready channel, tagging the final word of the command.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_rd_ctrl #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    output logic              rf_rd_en,
    output logic [ADDR_W-1:0] rf_rd_addr,
    input  logic [WIDTH-1:0]  rf_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        CAP  = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] remaining;
    logic [ADDR_W-1:0] addr_inc;

    // Next sequential address, wrapping from the top register back to 0
    assign addr_inc = (cur_addr == ADDR_W'(DEPTH - 1)) ? '0 : cur_addr + ADDR_W'(1);

    // The read port always follows the current address; strobe is state-decoded
    assign rf_rd_addr = cur_addr;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and state-decoded handshake/strobe outputs
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        rf_rd_en  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                rf_rd_en  = 1'b1;
                state_nxt = CAP;
            end
            CAP: begin
                state_nxt = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = (remaining == '0) ? IDLE : REQ;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Command tracking and output word capture; output fields hold while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_addr  <= '0;
            remaining <= '0;
            out_data  <= '0;
            out_addr  <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cur_addr  <= cmd_addr;
                        remaining <= cmd_len;
                    end
                end
                CAP: begin
                    out_data <= rf_rd_data;
                    out_addr <= cur_addr;
                    out_last <= (remaining == '0);
                end
                OUT: begin
                    if (out_ready && (remaining != '0)) begin
                        remaining <= remaining - ADDR_W'(1);
                        cur_addr  <= addr_inc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/regfile_rd_ctrl.md
# regfile_rd_ctrl

Read-side controller for the 8x16 general register file. It accepts a read command (start address plus word count) over a valid/ready handshake and issues read strobes to the register file's synchronous read port. It captures each returned word and streams it out on a valid/ready output channel, tagging the last word. It is the reader that complements the existing write-only register file datapath.

## Interface
Parameters:
- WIDTH, 16, data word width
- DEPTH, 8, number of registers; must be a power of 2
- ADDR_W, 3, address width; equals log2(DEPTH)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  read command present
- cmd_ready  out  1  controller can accept a command
- cmd_addr  in  ADDR_W  first register address
- cmd_len  in  ADDR_W  number of words minus 1 (0 means 1 word, DEPTH-1 means DEPTH words)
- rf_rd_en  out  1  read strobe to the register file
- rf_rd_addr  out  ADDR_W  read address to the register file
- rf_rd_data  in  WIDTH  read data, valid the cycle after rf_rd_en
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts the word
- out_data  out  WIDTH  register contents
- out_addr  out  ADDR_W  address the word came from
- out_last  out  1  final word of the command
- busy  out  1  high whenever the state is not IDLE

## Operation
- FSM states: IDLE, REQ, CAP, OUT.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready: latch cmd_addr into cur_addr and cmd_len into remaining, then go to REQ.
- REQ:
  - rf_rd_en=1 and rf_rd_addr=cur_addr for exactly one cycle.
  - Go to CAP.
- CAP:
  - Register rf_rd_data into out_data and cur_addr into out_addr.
  - Set out_last = (remaining==0).
  - Go to OUT.
- OUT:
  - out_valid=1. out_data, out_addr and out_last are held stable until out_valid&out_ready.
  - On the handshake with remaining==0: go to IDLE.
  - On the handshake with remaining>0: decrement remaining, set cur_addr = cur_addr+1 mod DEPTH, go to REQ.
  - Without out_ready: stay in OUT. No new read is issued.
- Address wrap: DEPTH-1 is followed by 0. For example, addr=6, len=3 reads 6,7,0,1.
- Only one read is ever outstanding, so backpressure never causes data loss.
- cmd_ready=0 outside IDLE. cmd_valid asserted there is ignored and is not queued.
- rf_rd_addr is driven from cur_addr in all states. It is 0 in IDLE after reset.
- Reset (any state, including mid-command):
  - state=IDLE.
  - cmd_ready=1.
  - rf_rd_en=0, out_valid=0, out_last=0, busy=0.
  - out_data=0, out_addr=0, rf_rd_addr=0.
  - remaining=0, cur_addr=0.
  - The in-flight command is discarded and nothing is emitted after reset release.

## Timing
- Command accepted at edge E0 gives:
  - rf_rd_en high in cycle E0..E1.
  - Data captured at E2.
  - out_valid high from E2 onward.
- First-word latency: 2 cycles from the command handshake to out_valid.
- Steady-state throughput with out_ready held high: 1 word per 3 cycles.
- Handshake at the last word at edge Ek: cmd_ready is high in the cycle after Ek. A back-to-back command can be accepted at Ek+1.
- out_ready is sampled only in OUT, at the clock edge. out_ready in other states has no effect.
- All outputs are registered or decoded from state only. There are no combinational paths from inputs to outputs.

## Test plan
- Reset, then preload the file via the write port with REG[k]=16'h1000+k. Command addr=2, len=0 with out_ready=1:
  - Exactly one rf_rd_en pulse at address 2.
  - out_data=16'h1002, out_addr=2, out_last=1.
  - busy low 1 cycle after the handshake.
- Same file, addr=6, len=3, out_ready=1:
  - Words 1006,1007,1000,1001 at addresses 6,7,0,1.
  - out_last only on 1001.
  - Words appear 3 cycles apart.
- addr=0, len=7 with out_ready toggling pseudo-randomly:
  - All 8 words 1000..1007 delivered in order with no duplicates.
  - out_data stable while out_valid&!out_ready.
  - No rf_rd_en pulse during a stall.
- cmd_valid held high continuously across two commands (addr=3,len=1 then addr=5,len=0):
  - Second command accepted only in the cycle after the first command's last handshake.
  - cmd_ready=0 throughout the first command.
- Assert rst during OUT of a len=4 command, then release:
  - All outputs are 0 and cmd_ready=1 within the same cycle.
  - No further out_valid until a new command.
  - Next command addr=1,len=0 returns 16'h1001.
- Read immediately after reset with no preload, addr=4, len=1: returns 0 and 0, out_last on the second word.
